// File: rtl/bcd_scan_counter.sv
// Multi-digit BCD up/down counter with a multiplexed common-anode scan driver
// feeding a latched 7-segment decoder (lamp test, blank gaps, leading-zero blanking).
module bcd_scan_counter #(
    parameter int N_DIG      = 4,
    parameter int DIV_SCAN   = 1000,
    parameter int BLANK_CYC  = 8,
    parameter int LT_SCANS   = 2,
    parameter int ZERO_BLANK = 1
) (
    input  logic               Clk,
    input  logic               Reset_n,
    input  logic               Habilitar,
    input  logic               Sentido,
    input  logic               Cargar,
    input  logic [4*N_DIG-1:0] Dato,
    output logic [0:3]         Entradas,
    output logic [0:1]         LT_BI,
    output logic               LE,
    output logic [N_DIG-1:0]   Anodos,
    output logic               Desborde
);

    localparam int LAMP_LEN = LT_SCANS * N_DIG * DIV_SCAN;
    localparam int TW       = $clog2(LAMP_LEN);
    localparam int IW       = (N_DIG > 1) ? $clog2(N_DIG) : 1;

    localparam logic [TW-1:0] LAMP_LAST = TW'(LAMP_LEN - 1);
    localparam logic [TW-1:0] GAP_LAST  = TW'(BLANK_CYC - 1);
    localparam logic [TW-1:0] SHOW_LAST = TW'(DIV_SCAN - BLANK_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(N_DIG - 1);

    typedef enum logic [1:0] {LAMP, GAP, SHOW} state_t;

    state_t             state_q;
    logic [TW-1:0]      timer_q;
    logic [IW-1:0]      idx_q;
    logic [IW-1:0]      idx_nx;
    logic               lz_q;
    logic [4*N_DIG-1:0] cnt_q, cnt_d;
    logic               wrap_d, carry_c;
    logic               des_q;
    logic [3:0]         ent_q;
    logic [1:0]         ltbi_q;
    logic               le_q;
    logic [N_DIG-1:0]   an_q;

    function automatic logic [3:0] digit_at(input logic [4*N_DIG-1:0] v, input logic [IW-1:0] idx);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < N_DIG; i++)
            if (IW'(i) == idx) d = v[4*i +: 4];
        return d;
    endfunction

    // Blank only when this digit and every more-significant digit is zero; digit 0 always shows.
    function automatic logic lead_zero(input logic [4*N_DIG-1:0] v, input logic [IW-1:0] idx);
        logic z;
        z = 1'b1;
        for (int i = 0; i < N_DIG; i++)
            if (i >= int'(idx) && v[4*i +: 4] != 4'd0) z = 1'b0;
        return (ZERO_BLANK != 0) && (idx != '0) && z;
    endfunction

    function automatic logic [N_DIG-1:0] sel_mask(input logic [IW-1:0] idx);
        logic [N_DIG-1:0] m;
        m = '1;
        for (int i = 0; i < N_DIG; i++)
            if (IW'(i) == idx) m[i] = 1'b0;
        return m;
    endfunction

    // Decimal ripple: carry/borrow propagates while digits sit at their limit.
    always_comb begin
        cnt_d   = cnt_q;
        wrap_d  = 1'b0;
        carry_c = 1'b0;
        if (Cargar) begin
            for (int i = 0; i < N_DIG; i++)
                cnt_d[4*i +: 4] = (Dato[4*i +: 4] > 4'd9) ? 4'd0 : Dato[4*i +: 4];
        end else if (Habilitar) begin
            carry_c = 1'b1;
            for (int i = 0; i < N_DIG; i++) begin
                if (carry_c) begin
                    if (Sentido) begin
                        if (cnt_q[4*i +: 4] == 4'd9) begin
                            cnt_d[4*i +: 4] = 4'd0;
                        end else begin
                            cnt_d[4*i +: 4] = cnt_q[4*i +: 4] + 4'd1;
                            carry_c         = 1'b0;
                        end
                    end else begin
                        if (cnt_q[4*i +: 4] == 4'd0) begin
                            cnt_d[4*i +: 4] = 4'd9;
                        end else begin
                            cnt_d[4*i +: 4] = cnt_q[4*i +: 4] - 4'd1;
                            carry_c         = 1'b0;
                        end
                    end
                end
            end
            wrap_d = carry_c;
        end
    end

    assign idx_nx = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            cnt_q   <= '0;
            des_q   <= 1'b0;
            state_q <= LAMP;
            timer_q <= '0;
            idx_q   <= '0;
            lz_q    <= 1'b0;
            ent_q   <= 4'd0;
            ltbi_q  <= 2'b00;
            le_q    <= 1'b0;
            an_q    <= '0;
        end else begin
            cnt_q <= cnt_d;
            des_q <= wrap_d;
            case (state_q)
                LAMP: begin
                    if (timer_q == LAMP_LAST) begin
                        state_q <= GAP;
                        timer_q <= '0;
                        idx_q   <= '0;
                        ent_q   <= digit_at(cnt_q, '0);
                        lz_q    <= lead_zero(cnt_q, '0);
                        an_q    <= '1;
                        ltbi_q  <= 2'b10;
                        le_q    <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                GAP: begin
                    if (timer_q == GAP_LAST) begin
                        state_q <= SHOW;
                        timer_q <= '0;
                        an_q    <= sel_mask(idx_q);
                        ltbi_q  <= lz_q ? 2'b10 : 2'b11;
                        le_q    <= 1'b1;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                SHOW: begin
                    // Digit value is sampled only here, so Entradas is frozen while LE holds.
                    if (timer_q == SHOW_LAST) begin
                        state_q <= GAP;
                        timer_q <= '0;
                        idx_q   <= idx_nx;
                        ent_q   <= digit_at(cnt_q, idx_nx);
                        lz_q    <= lead_zero(cnt_q, idx_nx);
                        an_q    <= '1;
                        ltbi_q  <= 2'b10;
                        le_q    <= 1'b0;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= LAMP;
                    timer_q <= '0;
                end
            endcase
        end
    end

    assign Entradas = ent_q;
    assign LT_BI    = ltbi_q;
    assign LE       = le_q;
    assign Anodos   = an_q;
    assign Desborde = des_q;

endmodule
